sensor_seq_ctrl: RTL and testbench
==================================

// Module: sensor_seq_ctrl
// PURPOSE
//  Stage sequencer for the 3-bit sensor capture/commit registers. It drives
//  etapa[1:0] for all sensor instances: idle/settle -> capture -> commit.
//  It also watches the same raw input e[2:0] and commits only after e has
//  been stable; otherwise it retries, then flags an error.
//  Sits between the top-level anti-spoofing FSM (start/abort) and the sensor bank.
// PARAMETERS
//  SETTLE_CYC   4   cycles held in SETTLE (etapa=01) before capture; 1..255
//  STABLE_CYC   3   consecutive unchanged e cycles required in CAPTURE; 1..255
//  WINDOW_CYC   16  max cycles per CAPTURE attempt; 1..255, >= STABLE_CYC
//  MAX_RETRY    3   capture retries before error; 0..15
//  AUTORUN_PER  100 IDLE cycles between self-starts (only with macro); 1..255
// PORTS
//  clk      in   1  clock, all state on posedge
//  rst      in   1  async active-high reset
//  start    in   1  1-cycle request; sampled only in IDLE
//  abort    in   1  return to IDLE (see rules)
//  e        in   3  raw sensor input, same net the sensor bank sees
//  etapa    out  2  stage code to sensor bank: 00 IDLE, 01 SETTLE, 10 CAPTURE, 11 COMMIT
//  busy     out  1  high in every state except IDLE
//  done     out  1  1-cycle pulse, cycle after COMMIT
//  err      out  1  1-cycle pulse on retry exhaustion
//  value    out  3  registered copy of committed e (mirrors sensor s2)
//  retries  out  4  retries used in last/current run
// BEHAVIOUR
//  Reset: state=IDLE, etapa=00, busy=0, done=0, err=0, value=000, retries=0;
//   all counters 0. All outputs registered.
//  IDLE: start=1 & abort=0 -> SETTLE, retries<=0, cnt<=0.
//   start while busy is ignored (no queueing).
//  SETTLE (etapa=01): cnt counts to SETTLE_CYC-1, then -> CAPTURE.
//   On entry to CAPTURE: ref<=e, stab<=0, win<=0.
//  CAPTURE (etapa=10): every cycle win++.
//   e==ref: stab++; e!=ref: ref<=e, stab<=0.
//   stab reaching STABLE_CYC-1 with e==ref -> COMMIT, latch cap<=e.
//   Otherwise, if win reaches WINDOW_CYC-1:
//    retries<MAX_RETRY -> retries++, back to SETTLE (cnt<=0).
//    Else -> IDLE with err=1 for 1 cycle; value unchanged.
//   A stable run ending exactly on the last window cycle counts as success.
//  COMMIT (etapa=11): exactly 1 cycle; value<=cap; -> IDLE with done=1
//   for the following cycle.
//  Abort: in SETTLE/CAPTURE -> IDLE next cycle, no done/err, value unchanged.
//   In COMMIT, abort is ignored: the commit completes and done fires,
//   because the sensor bank latches on that edge anyway.
//   start+abort in IDLE: abort wins.
//  Counters 8-bit, saturating (never wrap); retries 4-bit.
//  rst mid-operation: immediate async return to reset values; etapa=00
//   guarantees the sensor bank stops capturing.
//  Sensor timing: the bank's s1 holds e from the last CAPTURE edge, which
//   equals cap.
// CONFIGURATION
//  SENSOR_SEQ_AUTORUN_EN defined: in IDLE an 8-bit idle counter runs.
//   Reaching AUTORUN_PER-1 self-starts exactly like start. Counter clears on
//   leaving IDLE, on start and on abort. An external start still works.
//  Not defined: no idle counter; runs begin only on start; AUTORUN_PER unused.
// TESTING
//  T1 reset: assert rst mid-CAPTURE -> etapa=00, busy=0, value=000, same cycle
//     (async).
//  T2 clean run, defaults: e=101 constant, start pulse -> etapa 01 for 4 cyc,
//     10 for 3 cyc, 11 for 1 cyc; done next cycle; value=101; retries=0.
//  T3 noisy: e toggles every cycle during first 2 CAPTURE windows, then steady
//     011 -> retries=2, done=1, value=011.
//  T4 exhaustion: e toggles forever -> 4 windows of 16 cycles, err pulse,
//     retries=3, value unchanged.
//  T5 abort: abort in CAPTURE -> IDLE next cycle, no done.
//     abort in COMMIT -> done=1, value updated. start+abort in IDLE -> stays IDLE.
//  T6 macro on, AUTORUN_PER=10: no start, e=110 -> first SETTLE 10 cycles after
//     reset; repeats 10 IDLE cycles after each done.

Source files
------------

// File: rtl/sensor_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sensor_seq_ctrl
// Description : Stage sequencer for the 3-bit sensor capture/commit registers.
//               Drives etapa[1:0] to every sensor instance
//               (IDLE 00 -> SETTLE 01 -> CAPTURE 10 -> COMMIT 11). It watches
//               the raw input e and commits only after e has been stable.
//               Otherwise it retries, and once the retries run out it raises
//               an error pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1  clock, all state on posedge
//   rst      in   1  asynchronous active-high reset
//   start    in   1  run request, sampled only in IDLE
//   abort    in   1  return to IDLE from SETTLE/CAPTURE (ignored in COMMIT)
//   e        in   3  raw sensor input, same net the sensor bank sees
//   etapa    out  2  stage code to the sensor bank
//   busy     out  1  high in every state except IDLE
//   done     out  1  1-cycle pulse, the cycle after COMMIT
//   err      out  1  1-cycle pulse when the retries are exhausted
//   value    out  3  committed copy of e (mirrors sensor s2)
//   retries  out  4  retries used in the last/current run
// Configuration macro
//   SENSOR_SEQ_AUTORUN_EN : when defined, an idle counter self-starts a run
//                           after AUTORUN_PER idle cycles.
// ============================================================================
module sensor_seq_ctrl #(
    parameter int SETTLE_CYC  = 4,
    parameter int STABLE_CYC  = 3,
    parameter int WINDOW_CYC  = 16,
    parameter int MAX_RETRY   = 3,
    parameter int AUTORUN_PER = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] e,
    output logic [1:0] etapa,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] value,
    output logic [3:0] retries
);

    // The state encoding equals the etapa code, so etapa comes straight from
    // the state register.
    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_SETTLE  = 2'b01;
    localparam logic [1:0] c_CAPTURE = 2'b10;
    localparam logic [1:0] c_COMMIT  = 2'b11;

    localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] c_STABLE_LAST = 8'(STABLE_CYC - 1);
    localparam logic [7:0] c_WINDOW_LAST = 8'(WINDOW_CYC - 1);
    localparam logic [3:0] c_MAX_RETRY   = 4'(MAX_RETRY);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0] r_state,   w_state_nxt;
    logic [7:0] r_cnt,     w_cnt_nxt;
    logic [7:0] r_win,     w_win_nxt;
    logic [7:0] r_stab,    w_stab_nxt;
    logic [2:0] r_ref,     w_ref_nxt;
    logic [2:0] r_cap,     w_cap_nxt;
    logic [2:0] r_value,   w_value_nxt;
    logic [3:0] r_retries, w_retries_nxt;
    logic       r_done,    w_done_nxt;
    logic       r_err,     w_err_nxt;
    logic       r_busy,    w_busy_nxt;
    logic       w_start_req;
    logic       w_hit;

`ifdef SENSOR_SEQ_AUTORUN_EN
    localparam logic [7:0] c_AUTORUN_LAST = 8'(AUTORUN_PER - 1);
    logic [7:0] r_idle_cnt;
    logic       w_auto_fire;

    assign w_auto_fire = (r_state == c_IDLE) && (r_idle_cnt == c_AUTORUN_LAST);

    // Held at zero outside IDLE, so each IDLE stretch counts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if ((r_state != c_IDLE) || start || abort || w_auto_fire) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= sat_inc(r_idle_cnt);
        end
    end

    assign w_start_req = start | w_auto_fire;
`else
    logic [7:0] w_unused_autorun;
    assign w_unused_autorun = 8'(AUTORUN_PER);
    assign w_start_req      = start;
`endif

    // A stable run has reached its length this cycle. It takes priority over
    // the window timeout, so a run that ends on the last window cycle commits.
    assign w_hit = (e == r_ref) && (r_stab == c_STABLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_win     <= '0;
            r_stab    <= '0;
            r_ref     <= '0;
            r_cap     <= '0;
            r_value   <= '0;
            r_retries <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_win     <= w_win_nxt;
            r_stab    <= w_stab_nxt;
            r_ref     <= w_ref_nxt;
            r_cap     <= w_cap_nxt;
            r_value   <= w_value_nxt;
            r_retries <= w_retries_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_win_nxt     = r_win;
        w_stab_nxt    = r_stab;
        w_ref_nxt     = r_ref;
        w_cap_nxt     = r_cap;
        w_value_nxt   = r_value;
        w_retries_nxt = r_retries;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            c_IDLE: begin
                if (w_start_req && !abort) begin
                    w_state_nxt   = c_SETTLE;
                    w_retries_nxt = '0;
                    w_cnt_nxt     = '0;
                end
            end
            c_SETTLE: begin
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else if (r_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = c_CAPTURE;
                    w_ref_nxt   = e;
                    w_stab_nxt  = '0;
                    w_win_nxt   = '0;
                end else begin
                    w_cnt_nxt = sat_inc(r_cnt);
                end
            end
            c_CAPTURE: begin
                if (abort) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_win_nxt = sat_inc(r_win);
                    if (w_hit) begin
                        w_state_nxt = c_COMMIT;
                        w_cap_nxt   = e;
                    end else begin
                        if (e == r_ref) begin
                            w_stab_nxt = sat_inc(r_stab);
                        end else begin
                            w_ref_nxt  = e;
                            w_stab_nxt = '0;
                        end
                        if (r_win == c_WINDOW_LAST) begin
                            if (r_retries < c_MAX_RETRY) begin
                                w_retries_nxt = r_retries + 4'd1;
                                w_state_nxt   = c_SETTLE;
                                w_cnt_nxt     = '0;
                            end else begin
                                w_state_nxt = c_IDLE;
                                w_err_nxt   = 1'b1;
                            end
                        end
                    end
                end
            end
            c_COMMIT: begin
                // Abort is ignored here: the sensor bank latches on this edge.
                w_value_nxt = r_cap;
                w_state_nxt = c_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != c_IDLE);
    end

    assign etapa   = r_state;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign value   = r_value;
    assign retries = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_sensor_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_seq_ctrl
// Description : Self-checking bench for sensor_seq_ctrl. It uses a per-cycle
//               vector table, hand-written multi-cycle sequences and
//               randomized runs. The randomized runs are checked against a
//               window-search timeline model.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : none (drives every port of sensor_seq_ctrl)
// Macro       : SENSOR_SEQ_AUTORUN_EN selects the autorun checks
// ============================================================================
module tb_sensor_seq_ctrl;

    localparam int c_S  = 4;
    localparam int c_ST = 3;
    localparam int c_W  = 16;
    localparam int c_MR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] e;
    logic [1:0] etapa;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] value;
    logic [3:0] retries;

    int errors = 0;
    int checks = 0;

    sensor_seq_ctrl #(
        .SETTLE_CYC (c_S),
        .STABLE_CYC (c_ST),
        .WINDOW_CYC (c_W),
        .MAX_RETRY  (c_MR),
        .AUTORUN_PER(10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .abort  (abort),
        .e      (e),
        .etapa  (etapa),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .value  (value),
        .retries(retries)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus and model storage shared by the sequence tasks.
    logic [2:0] e_seq   [0:255];
    logic [1:0] exp_et  [0:255];
    logic       exp_done[0:255];
    logic       exp_err [0:255];
    logic [2:0] exp_val [0:255];
    logic [3:0] exp_ret [0:255];
    int         ab_cycle;
    logic [2:0] prev_val;
    logic [3:0] prev_ret;

    typedef struct {
        logic       start;
        logic       abort;
        logic [2:0] e;
        logic [1:0] et;
        logic       done;
        logic       err;
        logic [2:0] val;
        logic [3:0] ret;
    } vec_t;

    vec_t tv[13];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, $signed(got), $signed(want));
        end
    endtask

    task automatic chk_vec(input string name, input logic [1:0] et, input logic d,
                           input logic er, input logic [2:0] v, input logic [3:0] r);
        logic [11:0] got, want;
        got  = {etapa, busy, done, err, value, retries};
        want = {et, (et != 2'b00), d, er, v, r};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got etapa/busy/done/err/value/retries=%b want %b",
                     name, got, want);
        end
    endtask

    function automatic bit all_same(input int from, input int n);
        for (int i = 1; i < n; i++)
            if (e_seq[from + i] != e_seq[from]) return 1'b0;
        return 1'b1;
    endfunction

    // Timeline model: run attempts as SETTLE blocks followed by CAPTURE
    // windows. An attempt commits at the first window cycle j where the last
    // STABLE+1 samples of e (the one latched on entry included) are all equal.
    task automatic build_model(output int len);
        int         t, c, r, j, eb;
        bit         found, fin, is_done;
        logic [2:0] nv;
        for (int k = 0; k < 256; k++) begin
            exp_et[k] = 2'b00; exp_done[k] = 1'b0; exp_err[k] = 1'b0;
            exp_val[k] = prev_val; exp_ret[k] = prev_ret;
        end
        t = 1; r = 0; fin = 1'b0; eb = 0; is_done = 1'b0; nv = prev_val;
        while (!fin) begin
            for (int i = 0; i < c_S; i++) begin
                exp_et[t + i] = 2'b01; exp_ret[t + i] = 4'(r);
            end
            c = t + c_S; found = 1'b0; j = 0;
            for (int jj = c_ST - 1; jj < c_W && !found; jj++)
                if (all_same(c + jj - c_ST, c_ST + 1)) begin
                    found = 1'b1; j = jj;
                end
            if (found) begin
                for (int i = 0; i <= j; i++) begin
                    exp_et[c + i] = 2'b10; exp_ret[c + i] = 4'(r);
                end
                exp_et[c + j + 1] = 2'b11; exp_ret[c + j + 1] = 4'(r);
                eb = c + j + 1; is_done = 1'b1; nv = e_seq[c + j]; fin = 1'b1;
            end else begin
                for (int i = 0; i < c_W; i++) begin
                    exp_et[c + i] = 2'b10; exp_ret[c + i] = 4'(r);
                end
                if (r == c_MR) begin
                    eb = c + c_W - 1; is_done = 1'b0; fin = 1'b1;
                end else begin
                    r++; t = c + c_W;
                end
            end
        end
        for (int k = eb + 1; k < 256; k++) begin
            exp_ret[k] = 4'(r);
            if (is_done) exp_val[k] = nv;
        end
        exp_done[eb + 1] = is_done;
        exp_err[eb + 1]  = !is_done;
        len = eb + 2;
        if (ab_cycle >= 1 && ab_cycle <= eb &&
            (exp_et[ab_cycle] == 2'b01 || exp_et[ab_cycle] == 2'b10)) begin
            for (int k = ab_cycle + 1; k < 256; k++) begin
                exp_et[k] = 2'b00; exp_done[k] = 1'b0; exp_err[k] = 1'b0;
                exp_val[k] = prev_val; exp_ret[k] = exp_ret[ab_cycle];
            end
            len = ab_cycle + 2;
        end
    endtask

    // Start at cycle 0, play e_seq and record the first done/err/return-to-idle.
    task automatic drive_seq(input int ab, input int budget,
                             output int td, output int te, output int ti);
        td = -1; te = -1; ti = -1;
        for (int k = 0; k < budget; k++) begin
            if (done === 1'b1 && td < 0) td = k;
            if (err === 1'b1 && te < 0) te = k;
            if (k > 0 && etapa === 2'b00 && ti < 0) ti = k;
            start = (k == 0);
            abort = (k == ab);
            e     = e_seq[k];
            step();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int td, te, ti, len, p, first_s, second_s, busy_cycles;
        logic [2:0] cur;
        logic [1:0] prev_et;

        rst = 1'b1; start = 1'b0; abort = 1'b0; e = 3'b000;
        step();
        step();
        chk_vec("reset_state", 2'b00, 1'b0, 1'b0, 3'b000, 4'd0);
        rst = 1'b0;

`ifdef SENSOR_SEQ_AUTORUN_EN
        // Self-start after 10 idle cycles, repeated 10 idle cycles after done.
        e = 3'b110;
        do_reset();
        first_s = -1; second_s = -1; td = -1; prev_et = 2'b00;
        for (int k = 0; k < 40; k++) begin
            if (etapa == 2'b01 && prev_et == 2'b00) begin
                if (first_s < 0) first_s = k;
                else if (second_s < 0) second_s = k;
            end
            if (done === 1'b1 && td < 0) td = k;
            prev_et = etapa;
            step();
        end
        chk("autorun_first_settle", 32'(first_s), 32'(10));
        chk("autorun_first_done", 32'(td), 32'(18));
        chk("autorun_second_settle", 32'(second_s), 32'(28));
        chk("autorun_value", 32'(value), 32'(3'b110));
`else
        // Without start the sequencer never leaves IDLE.
        busy_cycles = 0;
        for (int k = 0; k < 30; k++) begin
            if (etapa != 2'b00 || busy) busy_cycles++;
            e = 3'($urandom_range(0, 7));
            step();
        end
        chk("no_self_start", 32'(busy_cycles), 32'(0));

        // Clean run with e=101, an ignored start while busy, then start+abort.
        tv[0]  = '{1'b1, 1'b0, 3'b101, 2'b00, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[1]  = '{1'b0, 1'b0, 3'b101, 2'b01, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[2]  = '{1'b1, 1'b0, 3'b101, 2'b01, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[3]  = '{1'b0, 1'b0, 3'b101, 2'b01, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[4]  = '{1'b0, 1'b0, 3'b101, 2'b01, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[5]  = '{1'b0, 1'b0, 3'b101, 2'b10, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[6]  = '{1'b0, 1'b0, 3'b101, 2'b10, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[7]  = '{1'b0, 1'b0, 3'b101, 2'b10, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[8]  = '{1'b0, 1'b0, 3'b101, 2'b11, 1'b0, 1'b0, 3'b000, 4'd0};
        tv[9]  = '{1'b0, 1'b0, 3'b101, 2'b00, 1'b1, 1'b0, 3'b101, 4'd0};
        tv[10] = '{1'b0, 1'b0, 3'b101, 2'b00, 1'b0, 1'b0, 3'b101, 4'd0};
        tv[11] = '{1'b1, 1'b1, 3'b101, 2'b00, 1'b0, 1'b0, 3'b101, 4'd0};
        tv[12] = '{1'b0, 1'b0, 3'b101, 2'b00, 1'b0, 1'b0, 3'b101, 4'd0};
        for (int i = 0; i < 13; i++) begin
            chk_vec($sformatf("vec%0d", i), tv[i].et, tv[i].done, tv[i].err,
                    tv[i].val, tv[i].ret);
            start = tv[i].start;
            abort = tv[i].abort;
            e     = tv[i].e;
            step();
        end
        start = 1'b0; abort = 1'b0;

        // Asynchronous reset in the middle of CAPTURE.
        start = 1'b1; e = 3'b101;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("pre_reset_capture", 32'(etapa), 32'(2'b10));
        #2 rst = 1'b1;
        #1 chk_vec("async_reset", 2'b00, 1'b0, 1'b0, 3'b000, 4'd0);
        step();
        step();
        rst = 1'b0;

        // Noisy first two windows, then steady 011.
        for (int k = 0; k < 256; k++) e_seq[k] = (k > 40) ? 3'b011 : ((k % 2) ? 3'b010 : 3'b101);
        drive_seq(-1, 70, td, te, ti);
        chk("noisy_done_cycle", 32'(td), 32'(49));
        chk("noisy_no_err", 32'(te), -32'sd1);
        chk("noisy_retries", 32'(retries), 32'(2));
        chk("noisy_value", 32'(value), 32'(3'b011));

        // Endless toggling: 4 windows, then the error pulse.
        for (int k = 0; k < 256; k++) e_seq[k] = (k % 2) ? 3'b100 : 3'b001;
        drive_seq(-1, 95, td, te, ti);
        chk("exhaust_err_cycle", 32'(te), 32'(81));
        chk("exhaust_no_done", 32'(td), -32'sd1);
        chk("exhaust_retries", 32'(retries), 32'(3));
        chk("exhaust_value_kept", 32'(value), 32'(3'b011));

        // Abort in CAPTURE, then abort in COMMIT.
        for (int k = 0; k < 256; k++) e_seq[k] = 3'b110;
        drive_seq(6, 20, td, te, ti);
        chk("abort_capture_idle", 32'(ti), 32'(7));
        chk("abort_capture_no_done", 32'(td), -32'sd1);
        chk("abort_capture_value", 32'(value), 32'(3'b011));
        drive_seq(8, 15, td, te, ti);
        chk("abort_commit_done", 32'(td), 32'(9));
        chk("abort_commit_value", 32'(value), 32'(3'b110));

        // Randomized runs against the timeline model.
        do_reset();
        prev_val = 3'b000;
        prev_ret = 4'd0;
        for (int run = 0; run < 40; run++) begin
            case (run % 4)
                0: p = 0;
                1: p = 50;
                2: p = 85;
                default: p = 95;
            endcase
            cur = 3'($urandom_range(0, 7));
            for (int k = 0; k < 256; k++) begin
                if ($urandom_range(0, 99) >= p) cur = 3'($urandom_range(0, 7));
                e_seq[k] = cur;
            end
            ab_cycle = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 60)) : -1;
            build_model(len);
            for (int k = 0; k <= len; k++) begin
                chk_vec($sformatf("rand%0d_cyc%0d", run, k), exp_et[k], exp_done[k],
                        exp_err[k], exp_val[k], exp_ret[k]);
                if (k == 0)                  start = 1'b1;
                else if (exp_et[k] != 2'b00) start = 1'($urandom_range(0, 1));
                else                         start = 1'b0;
                abort = (k == ab_cycle);
                e     = e_seq[k];
                step();
            end
            start = 1'b0; abort = 1'b0;
            prev_val = exp_val[len];
            prev_ret = exp_ret[len];
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
